// File: rtl/fpnew_pkg.sv
// Shared constants, types and helpers for the slice-sharing arbiter.
// Imported by fpnew_share_id_fifo and fpnew_slice_share_arb.
package fpnew_pkg;

  localparam int unsigned MAX_SHARE_REQ = 8;
  localparam int unsigned PERF_CNT_W    = 16;

  typedef logic [PERF_CNT_W-1:0] perf_cnt_t;

  localparam perf_cnt_t PERF_CNT_MAX = '1;

  // A single requester still needs one ID bit so the FIFO has a data path.
  function automatic int unsigned share_id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fpnew_share_id_fifo.sv
// In-order requester-ID FIFO: pointer-based storage with an occupancy counter.
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module fpnew_share_id_fifo
  import fpnew_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth) + 1;

  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             push_en, pop_en;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      cnt_d = cnt_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push_en) mem_d[wr_ptr_q] = push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is qualified by the counter, so it needs no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fpnew_slice_share_arb.sv
// Round-robin sharing of one FP opgroup slice between NumReq requesters; an ID FIFO
// steers results back in order. Define FPNEW_SHARE_ARB_PERF_EN for grant counters.
module fpnew_slice_share_arb
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned MaxInflight = 4,
  parameter type         PayloadType = logic [31:0],
  parameter type         ResultType  = logic [31:0]
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NumReq-1:0]           req_valid_i,
  output logic [NumReq-1:0]           req_ready_o,
  input  PayloadType                  req_payload_i [NumReq],
  output logic                        slc_valid_o,
  input  logic                        slc_ready_i,
  output PayloadType                  slc_payload_o,
  output logic                        slc_flush_o,
  input  logic                        slc_out_valid_i,
  output logic                        slc_out_ready_o,
  input  ResultType                   slc_result_i,
  output logic [NumReq-1:0]           rsp_valid_o,
  input  logic [NumReq-1:0]           rsp_ready_i,
  output ResultType                   rsp_result_o,
  output logic                        busy_o,
  output logic [NumReq-1:0][15:0]     perf_grants_o
);

  localparam int unsigned IdW = share_id_width(NumReq);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic           lock_q, lock_d;
  logic [IdW-1:0] lock_id_q, lock_id_d;

  logic [IdW-1:0] arb_id;
  logic           arb_found;
  logic [IdW-1:0] gnt_id;
  logic           gnt_valid;
  logic           issue;

  logic           fifo_full, fifo_empty, fifo_pop;
  logic [IdW-1:0] head_id;

  // Round-robin search starting at the pointer.
  always_comb begin
    int unsigned    idx;
    logic [IdW-1:0] idx_w;
    arb_id    = ptr_q;
    arb_found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx   = (int'(ptr_q) + i) % NumReq;
      idx_w = IdW'(idx);
      if (!arb_found && req_valid_i[idx_w]) begin
        arb_found = 1'b1;
        arb_id    = idx_w;
      end
    end
  end

  // A stalled offer keeps its grant so the slice sees a stable payload.
  assign gnt_id    = lock_q ? lock_id_q : arb_id;
  assign gnt_valid = lock_q ? req_valid_i[lock_id_q] : arb_found;

  assign slc_valid_o   = gnt_valid & ~fifo_full & ~flush_i;
  assign slc_payload_o = req_payload_i[gnt_id];
  assign slc_flush_o   = flush_i;
  assign issue         = slc_valid_o & slc_ready_i;

  always_comb begin
    req_ready_o         = '0;
    req_ready_o[gnt_id] = issue;
  end

  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = slc_valid_o & ~slc_ready_i;
    lock_id_d = gnt_id;
    if (issue) ptr_d = (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + IdW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  fpnew_share_id_fifo #(
    .Depth (MaxInflight),
    .Width (IdW)
  ) i_id_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (issue),
    .push_data_i (gnt_id),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head_id)
  );

  // Orphan results (empty FIFO) and results during flush are drained and dropped.
  always_comb begin
    rsp_valid_o = '0;
    if (slc_out_valid_i && !fifo_empty && !flush_i) rsp_valid_o[head_id] = 1'b1;
    slc_out_ready_o = (fifo_empty || flush_i) ? 1'b1 : rsp_ready_i[head_id];
  end

  assign fifo_pop     = slc_out_valid_i & slc_out_ready_o & ~flush_i;
  assign rsp_result_o = slc_result_i;
  assign busy_o       = ~fifo_empty | slc_valid_o;

`ifdef FPNEW_SHARE_ARB_PERF_EN
  perf_cnt_t [NumReq-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (issue && (perf_q[gnt_id] != PERF_CNT_MAX)) perf_d[gnt_id] = perf_q[gnt_id] + perf_cnt_t'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_grants_o = perf_q;
`else
  assign perf_grants_o = '0;
`endif

  orphan_result_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(slc_out_valid_i && fifo_empty && !flush_i));

endmodule

// File: tb/tb_fpnew_slice_share_arb.sv
// Directed self-checking bench for fpnew_slice_share_arb (NumReq=2, MaxInflight=4).
module tb_fpnew_slice_share_arb;

  localparam logic [31:0] PA = 32'hAAAA_0000;
  localparam logic [31:0] PB = 32'hBBBB_1111;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [31:0]       req_payload [2];
  logic              slc_valid;
  logic              slc_ready;
  logic [31:0]       slc_payload;
  logic              slc_flush;
  logic              slc_out_valid;
  logic              slc_out_ready;
  logic [31:0]       slc_result;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_result;
  logic              busy;
  logic [1:0][15:0]  perf_grants;

  int checks = 0;
  int errors = 0;

  fpnew_slice_share_arb #(
    .NumReq      (2),
    .MaxInflight (4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_payload_i   (req_payload),
    .slc_valid_o     (slc_valid),
    .slc_ready_i     (slc_ready),
    .slc_payload_o   (slc_payload),
    .slc_flush_o     (slc_flush),
    .slc_out_valid_i (slc_out_valid),
    .slc_out_ready_o (slc_out_ready),
    .slc_result_i    (slc_result),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .busy_o          (busy),
    .perf_grants_o   (perf_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [1:0] rv, input logic sr, input logic ov,
                       input logic [1:0] rr, input logic [31:0] res, input logic fl);
    @(negedge clk);
    req_valid     = rv;
    slc_ready     = sr;
    slc_out_valid = ov;
    rsp_ready     = rr;
    slc_result    = res;
    flush         = fl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (slc_valid !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got slc_valid=%b req_ready=%b rsp_valid=%b busy=%b want 0 00 00 0",
               slc_valid, req_ready, rsp_valid, busy);
    end
    checks++;
    if (perf_grants !== 32'h0) begin
      errors++;
      $display("FAIL reset_perf: got %h want 00000000", perf_grants);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
      checks++;
      if (req_ready !== exp_g[i] || slc_valid !== 1'b1) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got ready=%b valid=%b want ready=%b valid=1", i, req_ready, slc_valid, exp_g[i]);
      end
      checks++;
      if (slc_payload !== (exp_g[i][0] ? PA : PB)) begin
        errors++;
        $display("FAIL alt_payload[%0d]: got %h want %h", i, slc_payload, exp_g[i][0] ? PA : PB);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b11, 32'hC0DE_0000 + i, 1'b0);
      checks++;
      if (rsp_valid !== exp_g[i] || slc_out_ready !== 1'b1 || rsp_result !== 32'hC0DE_0000 + i) begin
        errors++;
        $display("FAIL alt_rsp[%0d]: got valid=%b ready=%b result=%h want valid=%b ready=1 result=%h",
                 i, rsp_valid, slc_out_ready, rsp_result, exp_g[i], 32'hC0DE_0000 + i);
      end
    end
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL alt_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_lock();
    drive(2'b10, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (slc_valid !== 1'b1 || slc_payload !== PB || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL lock_c0: got valid=%b payload=%h ready=%b want 1 %h 00", slc_valid, slc_payload, req_ready, PB);
    end
    for (int i = 1; i < 3; i++) begin
      drive(2'b11, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
      checks++;
      if (slc_payload !== PB || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL lock_hold[%0d]: got payload=%h ready=%b want %h 00", i, slc_payload, req_ready, PB);
      end
    end
    drive(2'b11, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (req_ready !== 2'b10 || slc_payload !== PB) begin
      errors++;
      $display("FAIL lock_accept: got ready=%b payload=%h want 10 %h", req_ready, slc_payload, PB);
    end
    drive(2'b11, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (req_ready !== 2'b01 || slc_payload !== PA) begin
      errors++;
      $display("FAIL lock_next: got ready=%b payload=%h want 01 %h", req_ready, slc_payload, PA);
    end
  endtask

  task automatic test_rsp_stall();
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b01, 32'h5555_0001, 1'b0);
      checks++;
      if (slc_out_ready !== 1'b0 || rsp_valid !== 2'b10) begin
        errors++;
        $display("FAIL stall[%0d]: got out_ready=%b rsp_valid=%b want 0 10", i, slc_out_ready, rsp_valid);
      end
    end
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'h5555_0001, 1'b0);
    checks++;
    if (slc_out_ready !== 1'b1 || rsp_valid !== 2'b10) begin
      errors++;
      $display("FAIL stall_release: got out_ready=%b rsp_valid=%b want 1 10", slc_out_ready, rsp_valid);
    end
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'h5555_0002, 1'b0);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'h5555_0002) begin
      errors++;
      $display("FAIL stall_second: got rsp_valid=%b result=%h want 01 55550002", rsp_valid, rsp_result);
    end
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
      checks++;
      if (req_ready !== 2'b01) begin
        errors++;
        $display("FAIL full_issue[%0d]: got ready=%b want 01", i, req_ready);
      end
    end
    drive(2'b01, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (slc_valid !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_block: got valid=%b ready=%b busy=%b want 0 00 1", slc_valid, req_ready, busy);
    end
    drive(2'b01, 1'b1, 1'b1, 2'b11, 32'h0000_0F0F, 1'b0);
    checks++;
    if (slc_valid !== 1'b0 || rsp_valid !== 2'b01 || slc_out_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_no_bypass: got valid=%b rsp_valid=%b out_ready=%b want 0 01 1", slc_valid, rsp_valid, slc_out_ready);
    end
    drive(2'b01, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (slc_valid !== 1'b1 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL full_after_pop: got valid=%b ready=%b want 1 01", slc_valid, req_ready);
    end
  endtask

  task automatic test_flush();
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'h0, 1'b0);
    drive(2'b11, 1'b1, 1'b1, 2'b11, 32'h0, 1'b1);
    checks++;
    if (rsp_valid !== 2'b00 || slc_valid !== 1'b0 || req_ready !== 2'b00 || slc_flush !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle: got rsp_valid=%b valid=%b ready=%b slc_flush=%b want 00 0 00 1",
               rsp_valid, slc_valid, req_ready, slc_flush);
    end
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (busy !== 1'b0 || slc_flush !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got busy=%b slc_flush=%b want 0 0", busy, slc_flush);
    end
    drive(2'b11, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (req_ready !== 2'b10 || slc_payload !== PB) begin
      errors++;
      $display("FAIL flush_ptr_kept: got ready=%b payload=%h want 10 %h", req_ready, slc_payload, PB);
    end
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'h1234_5678, 1'b0);
    checks++;
    if (rsp_valid !== 2'b10 || rsp_result !== 32'h1234_5678) begin
      errors++;
      $display("FAIL flush_new_rsp: got rsp_valid=%b result=%h want 10 12345678", rsp_valid, rsp_result);
    end
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic test_perf();
`ifdef FPNEW_SHARE_ARB_PERF_EN
    checks++;
    if (perf_grants[0] !== 16'd8 || perf_grants[1] !== 16'd4) begin
      errors++;
      $display("FAIL perf_counts: got %0d %0d want 8 4", perf_grants[0], perf_grants[1]);
    end
    drive(2'b01, 1'b1, 1'b0, 2'b11, 32'h0, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      slc_out_valid = 1'b1;
    end
    drive(2'b00, 1'b0, 1'b1, 2'b11, 32'h0, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (perf_grants[0] !== 16'hFFFF || perf_grants[1] !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL perf_saturate: got %h %h busy=%b want ffff 0004 0", perf_grants[0], perf_grants[1], busy);
    end
`else
    checks++;
    if (perf_grants !== 32'h0) begin
      errors++;
      $display("FAIL perf_disabled: got %h want 00000000", perf_grants);
    end
`endif
  endtask

  task automatic test_async_reset();
    drive(2'b01, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_busy: got %b want 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || perf_grants !== 32'h0) begin
      errors++;
      $display("FAIL areset_clear: got busy=%b perf=%h want 0 00000000", busy, perf_grants);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL areset_ptr: got ready=%b want 01", req_ready);
    end
    drive(2'b00, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    req_valid      = '0;
    slc_ready      = 1'b0;
    slc_out_valid  = 1'b0;
    rsp_ready      = '0;
    slc_result     = '0;
    req_payload[0] = PA;
    req_payload[1] = PB;
    test_reset();
    test_alternate();
    test_lock();
    test_rsp_stall();
    test_full();
    test_flush();
    test_perf();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
